// File: rtl/branch_resolve_unit_pkg.sv
// Shared decode constants, FSM state type and immediate extractors for the
// fetch predictor and the execute-stage branch resolver.
package branch_resolve_unit_pkg;

    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic {
        IDLE,
        FLUSH
    } state_e;

    function automatic logic [31:0] imm_b(input logic [31:0] instr);
        return {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] instr);
        return {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

    function automatic logic [31:0] imm_i(input logic [31:0] instr);
        return {{21{instr[31]}}, instr[30:20]};
    endfunction

endpackage

// File: rtl/branch_resolve_unit_cmp.sv
// Conditional-branch comparator: funct3 plus both operands -> taken.
// Reserved funct3 encodings resolve as not-taken.
module branch_cmp
    import branch_resolve_unit_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    output logic        taken_o
);

    always_comb begin
        taken_o = 1'b0;
        case (funct3_i)
            F3_BEQ:  taken_o = (rs1_i == rs2_i);
            F3_BNE:  taken_o = (rs1_i != rs2_i);
            F3_BLT:  taken_o = ($signed(rs1_i) <  $signed(rs2_i));
            F3_BGE:  taken_o = ($signed(rs1_i) >= $signed(rs2_i));
            F3_BLTU: taken_o = (rs1_i <  rs2_i);
            F3_BGEU: taken_o = (rs1_i >= rs2_i);
            default: taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution: computes real outcome/target, compares with
// the fetch prediction, redirects fetch and flushes IF/ID on a mismatch.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned COUNT_W      = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_valid,
    input  logic [31:0]        i_instr,
    input  logic [31:0]        i_pc,
    input  logic [31:0]        i_rs1_data,
    input  logic [31:0]        i_rs2_data,
    input  logic               i_pred_taken,
    input  logic [31:0]        i_pred_pc,
    output logic               o_redirect,
    output logic [31:0]        o_redirect_pc,
    output logic               o_flush,
    output logic [COUNT_W-1:0] o_branch_cnt,
    output logic [COUNT_W-1:0] o_mispred_cnt
);

    localparam int unsigned   FC_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES - 1);

    state_e             state_q, state_d;
    logic [FC_W-1:0]    flush_cnt_q, flush_cnt_d;
    logic               redirect_q;
    logic [31:0]        redirect_pc_q;
    logic [COUNT_W-1:0] branch_cnt_q, mispred_cnt_q;

    logic        is_branch, is_jal, is_jalr, is_ctrl;
    logic        cmp_taken, actual_taken, accept, mispredict;
    logic [31:0] target, fallthrough, correct_pc;
    logic        unused_instr_bits;

    assign unused_instr_bits = ^i_instr[1:0];

    branch_cmp u_cmp (
        .funct3_i (i_instr[14:12]),
        .rs1_i    (i_rs1_data),
        .rs2_i    (i_rs2_data),
        .taken_o  (cmp_taken)
    );

    always_comb begin
        is_branch   = (i_instr[6:2] == OP_BRANCH);
        is_jal      = (i_instr[6:2] == OP_JAL);
        is_jalr     = (i_instr[6:2] == OP_JALR);
        is_ctrl     = is_branch | is_jal | is_jalr;
        fallthrough = i_pc + 32'd4;
        target      = fallthrough;
        if (is_branch) target = i_pc + imm_b(i_instr);
        if (is_jal)    target = i_pc + imm_j(i_instr);
        if (is_jalr)   target = (i_rs1_data + imm_i(i_instr)) & ~32'd1;
        actual_taken = is_jal | is_jalr | (is_branch & cmp_taken);
        correct_pc   = actual_taken ? target : fallthrough;
        accept       = i_valid && (state_q == IDLE);
        // Non-control instrs fall out naturally: actual_taken=0, so pred_taken=1 mismatches.
        mispredict   = accept && ((actual_taken != i_pred_taken) ||
                                  (actual_taken && i_pred_taken && (i_pred_pc != target)));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            IDLE: begin
                if (mispredict) begin
                    state_d     = FLUSH;
                    flush_cnt_d = FC_LOAD;
                end
            end
            FLUSH: begin
                if (flush_cnt_q == '0) state_d = IDLE;
                else                   flush_cnt_d = flush_cnt_q - FC_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_flush = (state_q == FLUSH);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            redirect_q <= mispredict;
            if (mispredict) redirect_pc_q <= correct_pc;
            if (accept && is_ctrl && (branch_cnt_q != '1))
                branch_cnt_q <= branch_cnt_q + COUNT_W'(1);
            if (mispredict && (mispred_cnt_q != '1))
                mispred_cnt_q <= mispred_cnt_q + COUNT_W'(1);
        end
    end

    assign o_redirect    = redirect_q;
    assign o_redirect_pc = redirect_pc_q;
    assign o_branch_cnt  = branch_cnt_q;
    assign o_mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with a 4-bit counter width so that
// counter saturation is reachable in a short run.
module tb_branch_resolve_unit;

    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_valid;
    logic [31:0]   i_instr, i_pc, i_rs1_data, i_rs2_data, i_pred_pc;
    logic          i_pred_taken;
    logic          o_redirect, o_flush;
    logic [31:0]   o_redirect_pc;
    logic [CW-1:0] o_branch_cnt, o_mispred_cnt;

    int n_cmp = 0;
    int n_err = 0;

    branch_resolve_unit #(.FLUSH_CYCLES(2), .COUNT_W(CW)) dut (
        .clk           (clk),
        .reset         (reset),
        .i_valid       (i_valid),
        .i_instr       (i_instr),
        .i_pc          (i_pc),
        .i_rs1_data    (i_rs1_data),
        .i_rs2_data    (i_rs2_data),
        .i_pred_taken  (i_pred_taken),
        .i_pred_pc     (i_pred_pc),
        .o_redirect    (o_redirect),
        .o_redirect_pc (o_redirect_pc),
        .o_flush       (o_flush),
        .o_branch_cnt  (o_branch_cnt),
        .o_mispred_cnt (o_mispred_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [12:0] imm);
        return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_jal(input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_jalr(input logic [11:0] imm);
        return {imm, 5'd1, 3'b000, 5'd1, 7'b1100111};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic outs(input string tag, input logic rd, input logic [31:0] rpc,
                        input logic fl, input logic [CW-1:0] bc, input logic [CW-1:0] mc);
        check({tag, ".redirect"},    {31'd0, o_redirect}, {31'd0, rd});
        check({tag, ".redirect_pc"}, o_redirect_pc, rpc);
        check({tag, ".flush"},       {31'd0, o_flush}, {31'd0, fl});
        check({tag, ".branch_cnt"},  {28'd0, o_branch_cnt}, {28'd0, bc});
        check({tag, ".mispred_cnt"}, {28'd0, o_mispred_cnt}, {28'd0, mc});
    endtask

    task automatic issue(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic pt, input logic [31:0] ppc);
        i_valid = 1'b1; i_instr = instr; i_pc = pc;
        i_rs1_data = rs1; i_rs2_data = rs2; i_pred_taken = pt; i_pred_pc = ppc;
    endtask

    task automatic idle();
        i_valid = 1'b0; i_pred_taken = 1'b0; i_instr = 32'h0000_0013;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [CW-1:0] exp_mc;
        reset = 1'b1;
        i_pc = '0; i_rs1_data = '0; i_rs2_data = '0; i_pred_pc = '0;
        idle();
        #3;
        outs("reset", 1'b0, 32'h0, 1'b0, 4'd0, 4'd0);
        cyc(); cyc();
        reset = 1'b0;

        // 1: correctly predicted taken BEQ
        issue(enc_b(3'b000, 13'h040), 32'h100, 32'd5, 32'd5, 1'b1, 32'h140);
        cyc(); idle();
        outs("beq_ok", 1'b0, 32'h0, 1'b0, 4'd1, 4'd0);

        // 2: BNE predicted taken but falls through
        issue(enc_b(3'b001, 13'h020), 32'h200, 32'd7, 32'd7, 1'b1, 32'h220);
        cyc(); idle();
        outs("bne_mp", 1'b1, 32'h204, 1'b1, 4'd2, 4'd1);
        cyc();
        outs("bne_fl2", 1'b0, 32'h204, 1'b1, 4'd2, 4'd1);
        cyc();
        outs("bne_end", 1'b0, 32'h204, 1'b0, 4'd2, 4'd1);

        // 3: JALR predicted not-taken, target bit0 cleared
        issue(enc_jalr(12'h004), 32'h300, 32'h1001, 32'd0, 1'b0, 32'h0);
        cyc();
        outs("jalr_mp", 1'b1, 32'h1004, 1'b1, 4'd3, 4'd2);

        // 4: mispredicting BLTU during FLUSH is ignored, then accepted back-to-back
        issue(enc_b(3'b110, 13'h010), 32'h400, 32'd1, 32'd2, 1'b0, 32'h0);
        cyc();
        outs("flush_ign1", 1'b0, 32'h1004, 1'b1, 4'd3, 4'd2);
        cyc();
        outs("flush_ign2", 1'b0, 32'h1004, 1'b0, 4'd3, 4'd2);
        cyc(); idle();
        outs("b2b_bltu", 1'b1, 32'h410, 1'b1, 4'd4, 4'd3);
        cyc(); cyc();

        // JAL taken-taken with wrong predicted target
        issue(enc_jal(21'h000800), 32'h500, 32'd0, 32'd0, 1'b1, 32'hD04);
        cyc(); idle();
        outs("jal_badpc", 1'b1, 32'hD00, 1'b1, 4'd5, 4'd4);
        cyc(); cyc();

        // Non-control instr predicted taken
        issue(32'h0010_8093, 32'h600, 32'd0, 32'd0, 1'b1, 32'h700);
        cyc(); idle();
        outs("alu_pt", 1'b1, 32'h604, 1'b1, 4'd5, 4'd5);
        cyc(); cyc();

        // BGE signed: 0x80000000 < 1, so not taken, prediction correct
        issue(enc_b(3'b101, 13'h020), 32'h680, 32'h8000_0000, 32'd1, 1'b0, 32'h0);
        cyc(); idle();
        outs("bge_signed", 1'b0, 32'h604, 1'b0, 4'd6, 4'd5);

        // BLT taken with negative offset: 0x700 - 8
        issue(enc_b(3'b100, 13'h1FF8), 32'h700, 32'hFFFF_FFFF, 32'd0, 1'b0, 32'h0);
        cyc(); idle();
        outs("blt_neg", 1'b1, 32'h6F8, 1'b1, 4'd7, 4'd6);
        cyc(); cyc();

        // Reserved funct3 on BRANCH: not taken, still counted
        issue(enc_b(3'b010, 13'h020), 32'h800, 32'd1, 32'd1, 1'b0, 32'h0);
        cyc(); idle();
        outs("f3_rsvd", 1'b0, 32'h6F8, 1'b0, 4'd8, 4'd6);

        // 5: async reset in the first FLUSH cycle
        issue(enc_b(3'b001, 13'h020), 32'h200, 32'd7, 32'd7, 1'b1, 32'h220);
        cyc(); idle();
        outs("pre_rst", 1'b1, 32'h204, 1'b1, 4'd9, 4'd7);
        #2 reset = 1'b1;
        #1;
        outs("async_rst", 1'b0, 32'h0, 1'b0, 4'd0, 4'd0);
        cyc();
        reset = 1'b0;

        // 6: 17 mispredicts, counter saturates at 4'hF
        exp_mc = '0;
        for (int k = 0; k < 17; k++) begin
            issue(32'h0010_8093, 32'h900, 32'd0, 32'd0, 1'b1, 32'h0);
            cyc(); idle();
            exp_mc = (exp_mc == 4'hF) ? 4'hF : exp_mc + 4'd1;
            check("sat.mispred_cnt", {28'd0, o_mispred_cnt}, {28'd0, exp_mc});
            cyc(); cyc();
        end
        check("sat.final", {28'd0, o_mispred_cnt}, 32'hF);
        check("sat.branch_cnt", {28'd0, o_branch_cnt}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
